// File: rtl/gdma_rdata_stream_pkg.sv
// gdma_rdata_stream_pkg: shared types and beat/byte-enable helpers for the GDMA read-data stream.
package gdma_rdata_stream_pkg;
    typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    function automatic logic [32:0] ceil_beats(input logic [31:0] len, input int bytes);
        return ({1'b0, len} + 33'(bytes - 1)) / 33'(bytes);
    endfunction
    // Byte enables for the final beat; a zero tail means the last beat is full.
    function automatic logic [15:0] tkeep_last(input int tail);
        return (tail == 0) ? 16'hFFFF : 16'((32'd1 << tail) - 32'd1);
    endfunction
endpackage

// File: rtl/gdma_rdata_stream_if.sv
// gdma_rdata_stream_if: AXI4 R channel in, AXI4-Stream out.
interface gdma_rdata_stream_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic [DATA_W-1:0]   m_tdata;
    logic [DATA_W/8-1:0] m_tkeep;
    logic                m_tlast;
    logic                m_tvalid;
    logic                m_tready;
    modport master (output rdata, rresp, rlast, rvalid, m_tready,
                    input rready, m_tdata, m_tkeep, m_tlast, m_tvalid);
    modport slave (input rdata, rresp, rlast, rvalid, m_tready,
                   output rready, m_tdata, m_tkeep, m_tlast, m_tvalid);
endinterface

// File: rtl/gdma_rdata_stream_skid_fifo.sv
// gdma_rdata_stream_skid_fifo: synchronous FIFO with registered storage and full/empty flags.
module gdma_rdata_stream_skid_fifo #(
    parameter int W = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    // A pop frees the slot in the same cycle, so a full FIFO may still take a push.
    assign do_push = push && (!full || pop);
    assign do_pop = pop && !empty;
    assign full = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign dout = mem[rp];
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/gdma_rdata_stream.sv
// gdma_rdata_stream: forwards the AXI R channel as a paced AXI4-Stream with length-derived tlast/tkeep
// and sticky response/overrun errors.
module gdma_rdata_stream
    import gdma_rdata_stream_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_start,
    input  logic [31:0]          length,
    input  logic                 addr_done,
    output logic                 done,
    input  logic [DIV_W-1:0]     speed_divider,
    gdma_rdata_stream_if.slave   bus,
    output logic                 resp_err,
    output logic                 overrun_err
);
    localparam int BYTES = DATA_W / 8;
    state_t state;
    logic [32:0] in_rem, out_rem;
    logic [DIV_W-1:0] pace_cnt;
    logic [BYTES-1:0] keep_last;
    logic full, empty, r_hs, push, pop;
    logic unused;
    assign unused = bus.rlast;
    assign r_hs = bus.rvalid && bus.rready;
    assign push = r_hs && in_rem != '0;
    assign pop = bus.m_tvalid && bus.m_tready;
    assign bus.rready = state != IDLE && !full;
    assign bus.m_tvalid = !empty && pace_cnt == '0;
    assign bus.m_tlast = bus.m_tvalid && out_rem == 33'd1;
    assign bus.m_tkeep = !bus.m_tvalid ? '0 : bus.m_tlast ? keep_last : '1;
    gdma_rdata_stream_skid_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .din(bus.rdata),
        .pop(pop),
        .dout(bus.m_tdata),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            done <= 1'b1;
            in_rem <= '0;
            out_rem <= '0;
            pace_cnt <= '0;
            keep_last <= '0;
            resp_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            pace_cnt <= pop ? speed_divider : (pace_cnt != '0) ? pace_cnt - 1'b1 : pace_cnt;
            if (push) in_rem <= in_rem - 1'b1;
            if (pop && out_rem != '0) out_rem <= out_rem - 1'b1;
            // Beats beyond the programmed count are consumed but never reach the FIFO.
            if (r_hs && in_rem == '0) overrun_err <= 1'b1;
            if (r_hs && bus.rresp != AXI_RESP_OKAY) resp_err <= 1'b1;
            case (state)
                IDLE: if (op_start) begin
                    state <= RUN;
                    done <= 1'b0;
                    in_rem <= ceil_beats(length, BYTES);
                    out_rem <= ceil_beats(length, BYTES);
                    keep_last <= BYTES'(tkeep_last(int'(length % 32'(BYTES))));
                    resp_err <= 1'b0;
                    overrun_err <= 1'b0;
                end
                RUN: if (in_rem == '0 && out_rem == '0) state <= WAIT;
                WAIT: if (addr_done) begin
                    state <= IDLE;
                    done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
